// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// owner identifiers and the reserved-opcode test.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_FWD = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Opcodes above OR have no defined operation.
    function automatic logic is_reserved(input logic [2:0] sel);
        return (sel > OP_OR);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_pick2
    import alu_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_id    = OWN_A;
        if (req_a && req_b) begin
            gnt_id = ~last;
        end else if (req_b) begin
            gnt_id = OWN_B;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, holding the
// ALU inputs for ALU_WAIT cycles before capturing its result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned ALU_WAIT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_A,
    input  logic        REQ_B,
    input  logic [7:0]  DATA1_A,
    input  logic [7:0]  DATA2_A,
    input  logic [7:0]  DATA1_B,
    input  logic [7:0]  DATA2_B,
    input  logic [2:0]  SELECT_A,
    input  logic [2:0]  SELECT_B,
    output logic        DONE_A,
    output logic        DONE_B,
    output logic [7:0]  RESULT,
    output logic        ERROR,
    output logic        BUSY,
    output logic [7:0]  ALU_DATA1,
    output logic [7:0]  ALU_DATA2,
    output logic [2:0]  ALU_SELECT,
    input  logic [7:0]  ALU_RESULT,
    output logic [15:0] OP_COUNT
);

    localparam logic [2:0] WAIT_INIT = 3'(ALU_WAIT);

    state_t      state_q, state_d;
    owner_t      owner_q, last_q;
    logic [2:0]  cnt_q;
    logic [7:0]  alu_data1_q, alu_data2_q, result_q;
    logic [2:0]  alu_select_q;
    logic        error_q;
    logic [15:0] op_count_q;

    logic        gnt_valid, gnt_id;
    logic        accept, finish;

    rr_pick2 u_pick (
        .req_a     (REQ_A),
        .req_b     (REQ_B),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign accept = (state_q == ST_IDLE) && gnt_valid;
    assign finish = (state_q == ST_EXEC) && (cnt_q == 3'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_valid) state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == 3'd1) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state_q != ST_IDLE);
        DONE_A = (state_q == ST_DONE) && (owner_q == OWN_A);
        DONE_B = (state_q == ST_DONE) && (owner_q == OWN_B);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_q      <= OWN_A;
            last_q       <= OWN_B;
            cnt_q        <= '0;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_select_q <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            op_count_q   <= '0;
        end else begin
            if (accept) begin
                owner_q      <= owner_t'(gnt_id);
                last_q       <= owner_t'(gnt_id);
                cnt_q        <= WAIT_INIT;
                alu_data1_q  <= gnt_id ? DATA1_B  : DATA1_A;
                alu_data2_q  <= gnt_id ? DATA2_B  : DATA2_A;
                alu_select_q <= gnt_id ? SELECT_B : SELECT_A;
                error_q      <= 1'b0;
            end
            if (state_q == ST_EXEC) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Reserved opcodes still occupy the full wait but report zero.
            if (finish) begin
                result_q <= is_reserved(alu_select_q) ? 8'h00 : ALU_RESULT;
                error_q  <= is_reserved(alu_select_q);
            end
            if (state_q == ST_DONE) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign ALU_DATA1  = alu_data1_q;
    assign ALU_DATA2  = alu_data2_q;
    assign ALU_SELECT = alu_select_q;
    assign RESULT     = result_q;
    assign ERROR      = error_q;
    assign OP_COUNT   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with an external ALU and a transaction-level
// reference model of arbitration, results, latency and operation count.
module tb_alu_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [7:0]  data1_a, data2_a, data1_b, data2_b;
    logic [2:0]  select_a, select_b;
    logic        done_a, done_b;
    logic [7:0]  result;
    logic        error;
    logic        busy;
    logic [7:0]  alu_data1, alu_data2;
    logic [2:0]  alu_select;
    logic [7:0]  alu_result;
    logic [15:0] op_count;

    int vectors     = 0;
    int miscompares = 0;

    int unsigned model_count;
    bit          model_last;

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_WAIT(W)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .REQ_A      (req_a),
        .REQ_B      (req_b),
        .DATA1_A    (data1_a),
        .DATA2_A    (data2_a),
        .DATA1_B    (data1_b),
        .DATA2_B    (data2_b),
        .SELECT_A   (select_a),
        .SELECT_B   (select_b),
        .DONE_A     (done_a),
        .DONE_B     (done_b),
        .RESULT     (result),
        .ERROR      (error),
        .BUSY       (busy),
        .ALU_DATA1  (alu_data1),
        .ALU_DATA2  (alu_data2),
        .ALU_SELECT (alu_select),
        .ALU_RESULT (alu_result),
        .OP_COUNT   (op_count)
    );

    // External shared ALU; reserved opcodes produce a nonzero junk value.
    always_comb begin
        case (alu_select)
            3'd0:    alu_result = alu_data1;
            3'd1:    alu_result = alu_data1 + alu_data2;
            3'd2:    alu_result = alu_data1 & alu_data2;
            3'd3:    alu_result = alu_data1 | alu_data2;
            default: alu_result = alu_data1 | 8'hA5;
        endcase
    end

    // Reference: {error, result} for a completed operation.
    function automatic logic [8:0] ref_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(sel);
        if (s == 0) return {1'b0, a};
        if (s == 1) return {1'b0, 8'((int'(a) + int'(b)) % 256)};
        if (s == 2) return {1'b0, a & b};
        if (s == 3) return {1'b0, a | b};
        return {1'b1, 8'h00};
    endfunction

    function automatic bit ref_winner(input bit ra, input bit rb, input bit last);
        if (ra && rb) return !last;
        return rb;
    endfunction

    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (done_a || done_b) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        model_last  = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'd1;
        data1_b = 8'($urandom); data2_b = 8'($urandom); select_b = 3'd2;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done_a, done_b, error, result, alu_data1, alu_data2, alu_select, op_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b%b err=%b res=%h d1=%h d2=%h sel=%h cnt=%h, need all zero",
                     busy, done_a, done_b, error, result, alu_data1, alu_data2, alu_select, op_count);
        end
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        model_count = 0;
        model_last  = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: busy got %b need 0", busy);
        end
    endtask

    task automatic test_single_add;
        int n; bit seen;
        apply_reset();
        data1_a = 8'd17; data2_a = 8'd15; select_a = 3'd1; req_a = 1'b1;
        wait_done(n, seen);
        vectors++;
        if (!seen || n != W + 1) begin
            miscompares++;
            $display("FAIL add_latency: got %0d cycles (seen=%0b) need %0d", n, seen, W + 1);
        end
        vectors++;
        if ({done_a, done_b} !== 2'b10) begin
            miscompares++;
            $display("FAIL add_owner: done_a/b got %b%b need 10", done_a, done_b);
        end
        vectors++;
        if (result !== 8'd32 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL add_result: got res=%0d err=%b need res=32 err=0", result, error);
        end
        req_a = 1'b0;
        model_count++;
        model_last = 1'b0;
        @(negedge clk);
        vectors++;
        if (op_count !== 16'(model_count) || busy !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL add_count: got cnt=%0d busy=%b done_a=%b need cnt=%0d busy=0 done_a=0",
                     op_count, busy, done_a, model_count);
        end
    endtask

    task automatic test_tie;
        int n; bit seen;
        apply_reset();
        data1_a = 8'd17; data2_a = 8'd15; select_a = 3'd2;
        data1_b = 8'd17; data2_b = 8'd15; select_b = 3'd3;
        req_a = 1'b1; req_b = 1'b1;
        wait_done(n, seen);
        vectors++;
        if (!seen || {done_a, done_b} !== 2'b10 || result !== 8'd1) begin
            miscompares++;
            $display("FAIL tie_first: got seen=%0b done=%b%b res=%0d need done=10 res=1", seen, done_a, done_b, result);
        end
        req_a = 1'b0;
        model_count++;
        model_last = 1'b0;
        wait_done(n, seen);
        vectors++;
        if (!seen || n != W + 2 || {done_a, done_b} !== 2'b01 || result !== 8'd31) begin
            miscompares++;
            $display("FAIL tie_second: got seen=%0b n=%0d done=%b%b res=%0d need n=%0d done=01 res=31",
                     seen, n, done_a, done_b, result, W + 2);
        end
        req_b = 1'b0;
        model_count++;
        model_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alternate;
        int n; bit seen; bit w; logic [8:0] exp;
        apply_reset();
        data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'($urandom_range(0, 3));
        data1_b = 8'($urandom); data2_b = 8'($urandom); select_b = 3'($urandom_range(0, 3));
        req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w   = ref_winner(1'b1, 1'b1, model_last);
            exp = w ? ref_op(select_b, data1_b, data2_b) : ref_op(select_a, data1_a, data2_a);
            wait_done(n, seen);
            vectors++;
            if (!seen || n != ((k == 0) ? W + 1 : W + 2) || {done_a, done_b} !== (w ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL alt_grant[%0d]: got seen=%0b n=%0d done=%b%b need owner=%0d", k, seen, n, done_a, done_b, w);
            end
            vectors++;
            if ({error, result} !== exp) begin
                miscompares++;
                $display("FAIL alt_result[%0d]: got err=%b res=%h need %h", k, error, result, exp);
            end
            model_last = w;
            model_count++;
            if (w) begin
                data1_b = 8'($urandom); data2_b = 8'($urandom); select_b = 3'($urandom_range(0, 3));
            end else begin
                data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'($urandom_range(0, 3));
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        vectors++;
        if (op_count !== 16'd4) begin
            miscompares++;
            $display("FAIL alt_count: got %0d need 4", op_count);
        end
    endtask

    task automatic test_reserved;
        int n; bit seen;
        data1_b = 8'($urandom); data2_b = 8'($urandom); select_b = 3'd5; req_b = 1'b1;
        wait_done(n, seen);
        vectors++;
        if (!seen || n != W + 1 || {done_a, done_b} !== 2'b01 || error !== 1'b1 || result !== 8'h00) begin
            miscompares++;
            $display("FAIL rsv_done: got seen=%0b n=%0d done=%b%b err=%b res=%h need done=01 err=1 res=00",
                     seen, n, done_a, done_b, error, result);
        end
        vectors++;
        if (alu_data1 !== data1_b || alu_data2 !== data2_b || alu_select !== 3'd5) begin
            miscompares++;
            $display("FAIL rsv_operands: got %h %h %0d need %h %h 5", alu_data1, alu_data2, alu_select, data1_b, data2_b);
        end
        req_b = 1'b0;
        model_last = 1'b1;
        model_count++;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || error !== 1'b1 || result !== 8'h00) begin
            miscompares++;
            $display("FAIL rsv_hold: got busy=%b err=%b res=%h need busy=0 err=1 res=00", busy, error, result);
        end
        data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'd0; req_a = 1'b1;
        @(negedge clk);
        vectors++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_clear: got err=%b busy=%b need err=0 busy=1", error, busy);
        end
        wait_done(n, seen);
        vectors++;
        if (!seen || n != W || done_a !== 1'b1 || result !== data1_a) begin
            miscompares++;
            $display("FAIL rsv_next: got seen=%0b n=%0d done_a=%b res=%h need n=%0d res=%h", seen, n, done_a, result, W, data1_a);
        end
        req_a = 1'b0;
        model_last = 1'b0;
        model_count++;
        @(negedge clk);
    endtask

    task automatic test_operand_change;
        int n; bit seen; logic [8:0] exp;
        data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'($urandom_range(0, 3)); req_a = 1'b1;
        exp = ref_op(select_a, data1_a, data2_a);
        @(negedge clk);
        data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'($urandom_range(0, 7));
        wait_done(n, seen);
        vectors++;
        if (!seen || done_a !== 1'b1 || {error, result} !== exp) begin
            miscompares++;
            $display("FAIL latched_operands: got seen=%0b done_a=%b err=%b res=%h need %h", seen, done_a, error, result, exp);
        end
        req_a = 1'b0;
        model_last = 1'b0;
        model_count++;
        @(negedge clk);
    endtask

    task automatic test_random;
        int n; bit seen; bit w; logic [8:0] exp;
        bit rq[2];
        logic [7:0] d1[2], d2[2];
        logic [2:0] sl[2];
        rq[0] = 0; rq[1] = 0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq[i] && $urandom_range(0, 1) == 1) begin
                    rq[i] = 1; d1[i] = 8'($urandom); d2[i] = 8'($urandom); sl[i] = 3'($urandom_range(0, 7));
                end
            end
            if (!rq[0] && !rq[1]) begin
                w = 1'($urandom_range(0, 1));
                rq[w] = 1; d1[w] = 8'($urandom); d2[w] = 8'($urandom); sl[w] = 3'($urandom_range(0, 7));
            end
            req_a = rq[0]; data1_a = d1[0]; data2_a = d2[0]; select_a = sl[0];
            req_b = rq[1]; data1_b = d1[1]; data2_b = d2[1]; select_b = sl[1];
            w   = ref_winner(rq[0], rq[1], model_last);
            exp = ref_op(sl[w], d1[w], d2[w]);
            wait_done(n, seen);
            vectors++;
            if (!seen || n != W + 1 || {done_a, done_b} !== (w ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL rnd_grant[%0d]: got seen=%0b n=%0d done=%b%b need owner=%0d", k, seen, n, done_a, done_b, w);
            end
            vectors++;
            if ({error, result} !== exp || op_count !== 16'(model_count)) begin
                miscompares++;
                $display("FAIL rnd_result[%0d]: got err=%b res=%h cnt=%0d need %h cnt=%0d", k, error, result, op_count, exp, model_count);
            end
            model_last = w;
            model_count++;
            rq[w] = 0;
            if (w) req_b = 1'b0; else req_a = 1'b0;
            @(negedge clk);
        end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        vectors++;
        if (op_count !== 16'(model_count) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_count: got cnt=%0d busy=%b need cnt=%0d busy=0", op_count, busy, model_count);
        end
    endtask

    task automatic test_reset_mid_exec;
        int bad;
        data1_a = 8'($urandom) | 8'h01; data2_a = 8'($urandom); select_a = 3'd0; req_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre: got busy=%b done_a=%b need busy=1 done_a=0", busy, done_a);
        end
        reset = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        model_last  = 1'b1;
        vectors++;
        if ({busy, done_a, done_b, error, result, alu_data1, alu_data2, alu_select, op_count} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b%b err=%b res=%h d1=%h d2=%h sel=%h cnt=%h, need all zero",
                     busy, done_a, done_b, error, result, alu_data1, alu_data2, alu_select, op_count);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_a || done_b || busy) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d active cycles need 0", bad);
        end
    endtask

    task automatic test_wrap;
        int n; bit seen;
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        model_count = 32'hFFFF;
        data1_a = 8'($urandom); data2_a = 8'($urandom); select_a = 3'd3; req_a = 1'b1;
        wait_done(n, seen);
        vectors++;
        if (!seen || op_count !== 16'(model_count)) begin
            miscompares++;
            $display("FAIL wrap_pre: got seen=%0b cnt=%h need cnt=ffff", seen, op_count);
        end
        req_a = 1'b0;
        model_count = (model_count + 1) % 65536;
        @(negedge clk);
        vectors++;
        if (op_count !== 16'(model_count)) begin
            miscompares++;
            $display("FAIL wrap_post: got cnt=%h need cnt=%h", op_count, 16'(model_count));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        data1_a = '0; data2_a = '0; data1_b = '0; data2_b = '0;
        select_a = '0; select_b = '0;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_tie();
        test_alternate();
        test_reserved();
        test_operand_change();
        test_random();
        test_reset_mid_exec();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
